// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared FSM encoding, mux select codes and round-count constants for the AES round sequencer
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUND = 2'b01,
        ST_FINAL = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

    localparam logic [1:0] SEL_INIT  = 2'b00;
    localparam logic [1:0] SEL_ROUND = 2'b01;
    localparam logic [1:0] SEL_FINAL = 2'b11;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

endpackage

// File: rtl/aes_round_sequencer_mux3x1.sv
// rtl/aes_round_sequencer_mux3x1.sv - 3:1 next-state select (init / round / final) for the AES state register
module aes_round_sequencer_mux3x1
    import aes_pkg::*;
#(
    parameter int N = 128
) (
    input  logic [1:0]   i_sel,
    input  logic [N-1:0] i_init,
    input  logic [N-1:0] i_round,
    input  logic [N-1:0] i_final,
    output logic [N-1:0] o_y
);

    // Code 2'b10 is never driven by the sequencer; it falls back to the init leg.
    always_comb begin
        o_y = i_init;
        case (i_sel)
            SEL_ROUND: o_y = i_round;
            SEL_FINAL: o_y = i_final;
            default:   o_y = i_init;
        endcase
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES iterative round sequencer and state register; AES_SEQ_BACK2BACK_EN lets DONE hand off directly to a new block
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [N-1:0] round_data,
    input  logic [N-1:0] final_data,
    output logic [N-1:0] state_q,
    output logic [1:0]   sel,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    localparam logic [3:0] LP_LAST_ROUND = 4'(NR - 1);

    seq_state_t   r_state;
    seq_state_t   w_state_nxt;
    logic [N-1:0] r_state_q;
    logic [N-1:0] w_mux_out;
    logic [3:0]   r_round_idx;
    logic [3:0]   w_round_idx_nxt;
    logic [1:0]   w_sel;
    logic         w_load;
    logic         w_in_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_round_idx_nxt = r_round_idx;
        w_sel           = SEL_INIT;
        w_load          = 1'b0;
        w_in_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load          = 1'b1;
                    w_round_idx_nxt = 4'd1;
                    w_state_nxt     = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_sel           = SEL_ROUND;
                w_load          = 1'b1;
                w_round_idx_nxt = r_round_idx + 4'd1;
                if (r_round_idx == LP_LAST_ROUND) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_sel       = SEL_FINAL;
                w_load      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
`ifdef AES_SEQ_BACK2BACK_EN
                w_in_ready = out_ready;
`endif
                if (out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_round_idx_nxt = 4'd0;
`ifdef AES_SEQ_BACK2BACK_EN
                    // Retire the result and capture the next block on the same edge.
                    if (in_valid) begin
                        w_load          = 1'b1;
                        w_round_idx_nxt = 4'd1;
                        w_state_nxt     = ST_ROUND;
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    aes_round_sequencer_mux3x1 #(
        .N(N)
    ) u_mux (
        .i_sel  (w_sel),
        .i_init (in_data),
        .i_round(round_data),
        .i_final(final_data),
        .o_y    (w_mux_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_round_idx <= 4'd0;
            r_state_q   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_round_idx <= w_round_idx_nxt;
            if (w_load) begin
                r_state_q <= w_mux_out;
            end
        end
    end

    assign state_q   = r_state_q;
    assign out_data  = r_state_q;
    assign sel       = w_sel;
    assign round_idx = r_round_idx;
    assign in_ready  = w_in_ready;
    assign busy      = (r_state == ST_ROUND) || (r_state == ST_FINAL);
    assign out_valid = (r_state == ST_DONE);

endmodule
